button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 163 ++++++++++++++++
 tb/tb_button_conditioner.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Three-button front end: synchronises and debounces the raw buttons.
// Emits one-cycle press pulses, with auto-repeat and mutual lockout on inc/dec.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_TICKS = 2,
  parameter int unsigned REPEAT_DELAY   = 50,
  parameter int unsigned REPEAT_RATE    = 10
) (
  input  logic clk_100Hz,
  input  logic rst_n,
  input  logic btn_toggle_raw,
  input  logic btn_inc_raw,
  input  logic btn_dec_raw,
  output logic unit_toggle_press_once,
  output logic time_increment_press_once,
  output logic time_decrement_press_once
);

  localparam logic [7:0] DbTicks  = 8'(DEBOUNCE_TICKS);
  localparam logic [7:0] RptDelay = 8'(REPEAT_DELAY);
  localparam logic [7:0] RptRate  = 8'(REPEAT_RATE);

  typedef enum logic [1:0] {StIdle, StDelay, StRepeat, StLocked} state_e;

  // Channel index: 0 = toggle, 1 = inc, 2 = dec.
  logic [2:0] w_raw;
  logic [2:0] r_sync1, r_sync2;
  logic [2:0] r_db;
  logic [2:0] w_flip, w_db_next, w_rise;
  logic [2:0] w_pulse, r_pulse;
  logic [7:0] r_db_cnt     [3];
  logic [7:0] w_db_cnt_inc [3];
  logic       w_lock;

  assign w_raw = {btn_dec_raw, btn_inc_raw, btn_toggle_raw};

  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_db_cnt_inc[i] = (r_db_cnt[i] == 8'hFF) ? r_db_cnt[i] : r_db_cnt[i] + 8'd1;
      w_flip[i]       = (r_sync2[i] != r_db[i]) && (w_db_cnt_inc[i] == DbTicks);
      w_db_next[i]    = r_db[i] ^ w_flip[i];
      w_rise[i]       = w_flip[i] & ~r_db[i];
    end
  end

  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n) begin
      r_db <= '0;
      for (int i = 0; i < 3; i++) r_db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (w_flip[i]) begin
          r_db[i]     <= ~r_db[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= w_db_cnt_inc[i];
        end
      end
    end
  end

  // Lockout looks at the post-edge debounced state so same-edge rises are caught.
  assign w_lock     = w_db_next[1] & w_db_next[2];
  assign w_pulse[0] = w_rise[0];

  for (genvar g = 1; g < 3; g++) begin : g_rep
    state_e     r_state, w_state_next;
    logic [7:0] r_cnt, w_cnt_next, w_cnt_inc;
    logic       w_out;

    assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

    always_ff @(posedge clk_100Hz or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= StIdle;
        r_cnt   <= '0;
      end else begin
        r_state <= w_state_next;
        r_cnt   <= w_cnt_next;
      end
    end

    always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      if (w_lock) begin
        w_state_next = StLocked;
        w_cnt_next   = '0;
      end else begin
        unique case (r_state)
          StIdle: begin
            w_cnt_next = '0;
            if (w_rise[g]) w_state_next = StDelay;
          end
          StDelay: begin
            if (!r_db[g]) begin
              w_state_next = StIdle;
              w_cnt_next   = '0;
            end else if (w_cnt_inc == RptDelay) begin
              w_state_next = StRepeat;
              w_cnt_next   = '0;
            end else begin
              w_cnt_next = w_cnt_inc;
            end
          end
          StRepeat: begin
            if (!r_db[g]) begin
              w_state_next = StIdle;
              w_cnt_next   = '0;
            end else if (w_cnt_inc == RptRate) begin
              w_cnt_next = '0;
            end else begin
              w_cnt_next = w_cnt_inc;
            end
          end
          StLocked: begin
            w_cnt_next = '0;
            if (!r_db[g]) w_state_next = StIdle;
          end
          default: begin
            w_state_next = StIdle;
            w_cnt_next   = '0;
          end
        endcase
      end
    end

    always_comb begin
      w_out = 1'b0;
      if (!w_lock) begin
        unique case (r_state)
          StIdle:   w_out = w_rise[g];
          StDelay:  w_out = r_db[g] && (w_cnt_inc == RptDelay);
          StRepeat: w_out = r_db[g] && (w_cnt_inc == RptRate);
          default:  w_out = 1'b0;
        endcase
      end
    end

    assign w_pulse[g] = w_out;
  end

  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n) r_pulse <= '0;
    else        r_pulse <= w_pulse;
  end

  assign unit_toggle_press_once    = r_pulse[0];
  assign time_increment_press_once = r_pulse[1];
  assign time_decrement_press_once = r_pulse[2];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner at default parameters.
// Edge k is the k-th rising clock edge after stimulus for a sequence begins.
module tb_button_conditioner;

  logic clk_100Hz = 1'b0;
  logic rst_n;
  logic btn_toggle_raw, btn_inc_raw, btn_dec_raw;
  logic unit_toggle_press_once, time_increment_press_once, time_decrement_press_once;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0] btn;  // {dec, inc, toggle}
    logic [2:0] exp;  // {dec, inc, toggle} pulses after the edge
  } vec_t;

  vec_t vecs[$];
  int   q_tog[$], q_inc[$], q_dec[$];

  button_conditioner dut (
    .clk_100Hz                 (clk_100Hz),
    .rst_n                     (rst_n),
    .btn_toggle_raw            (btn_toggle_raw),
    .btn_inc_raw               (btn_inc_raw),
    .btn_dec_raw               (btn_dec_raw),
    .unit_toggle_press_once    (unit_toggle_press_once),
    .time_increment_press_once (time_increment_press_once),
    .time_decrement_press_once (time_decrement_press_once)
  );

  always #5 clk_100Hz = ~clk_100Hz;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] outs();
    return {time_decrement_press_once, time_increment_press_once, unit_toggle_press_once};
  endfunction

  task automatic check(input string name, input int k, input logic [2:0] exp);
    logic [2:0] got;
    got = outs();
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s edge %0d: got %b want %b ({dec,inc,tog})", name, k, got, exp);
    end
  endtask

  task automatic add_press(input logic [2:0] btn, input int hold, input logic [2:0] exp4);
    vec_t v;
    for (int k = 1; k <= 10; k++) begin
      v.btn = (k <= hold) ? btn : 3'b000;
      v.exp = (k == 4) ? exp4 : 3'b000;
      vecs.push_back(v);
    end
  endtask

  function automatic logic in_q(input int q[$], input int k);
    foreach (q[i]) if (q[i] == k) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic in_rng(input int k, input int a, input int b);
    return (k >= a) && (k <= b);
  endfunction

  task automatic run_seq(input string name, input int n,
                         input int t0, input int t1,
                         input int i0, input int i1, input int i2, input int i3,
                         input int d0, input int d1);
    logic [2:0] exp;
    for (int k = 1; k <= n; k++) begin
      btn_toggle_raw = in_rng(k, t0, t1);
      btn_inc_raw    = in_rng(k, i0, i1) || in_rng(k, i2, i3);
      btn_dec_raw    = in_rng(k, d0, d1);
      @(posedge clk_100Hz);
      #1;
      exp = {in_q(q_dec, k), in_q(q_inc, k), in_q(q_tog, k)};
      check(name, k, exp);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    btn_toggle_raw = 1'b0;
    btn_inc_raw    = 1'b0;
    btn_dec_raw    = 1'b0;
    #12;
    check("reset_outputs", 0, 3'b000);
    @(negedge clk_100Hz);
    rst_n = 1'b1;

    // Short presses from idle: glitch rejection, 2-cycle boundary, lockout.
    add_press(3'b010, 1, 3'b000);  // inc 1-cycle glitch
    add_press(3'b010, 3, 3'b010);  // inc 3 cycles
    add_press(3'b001, 3, 3'b001);  // toggle
    add_press(3'b100, 2, 3'b100);  // dec, exactly DEBOUNCE_TICKS
    add_press(3'b001, 1, 3'b000);  // toggle glitch
    add_press(3'b011, 3, 3'b011);  // toggle and inc together
    add_press(3'b100, 5, 3'b100);  // dec, released before repeat
    add_press(3'b110, 3, 3'b000);  // inc+dec same rise: locked
    for (int i = 0; i < vecs.size(); i++) begin
      {btn_dec_raw, btn_inc_raw, btn_toggle_raw} = vecs[i].btn;
      @(posedge clk_100Hz);
      #1;
      check("vec", i, vecs[i].exp);
    end

    // Inc held 100 cycles: initial, delayed and periodic repeats.
    q_tog.delete(); q_dec.delete();
    q_inc = '{4, 54, 64, 74, 84, 94, 104};
    run_seq("inc_hold", 130, 1, 0, 1, 100, 1, 0, 1, 0);

    // Toggle held 200 cycles: never repeats.
    q_inc.delete();
    q_tog = '{4};
    run_seq("tog_hold", 210, 1, 200, 1, 0, 1, 0, 1, 0);

    // Dec debounces high on the edge inc would repeat; lock persists after dec release.
    q_tog.delete();
    q_inc = '{4, 54, 64, 173};
    run_seq("lockout", 185, 1, 0, 1, 160, 170, 174, 71, 120);

    // Inc and dec rise together and are held.
    q_inc.delete();
    run_seq("same_rise", 110, 1, 0, 1, 100, 1, 0, 1, 100);

    // Async reset mid-REPEAT with inc held, then held-through-release press.
    q_inc = '{4, 54, 64, 74};
    run_seq("pre_rst", 74, 1, 0, 1, 74, 1, 0, 1, 0);
    rst_n = 1'b0;
    #1;
    check("rst_async", 0, 3'b000);
    @(negedge clk_100Hz);
    @(negedge clk_100Hz);
    rst_n = 1'b1;
    q_inc = '{4, 54};
    run_seq("post_rst", 70, 1, 0, 1, 58, 1, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
